// File: rtl/zxuno_regbank.sv
// rtl/zxuno_regbank.sv - ZX-UNO register address/data port pair with local register bank
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   a, iorq_n,
//   rd_n, wr_n, din  Z80 bus: address, strobes, CPU write data
//   autoinc          step the register address after every data-port access
//   dout, oe         read data and bus-drive enable back to the CPU
//   addr             current register address
//   regs_out         local registers, reg k in bits [8k+7:8k]
//   read_from_reg    one-clock pulse on a data-port read of a non-local address
//   write_to_reg     one-clock pulse on a data-port write of a non-local address
//   regaddr_changed  one-clock pulse after addr is loaded or incremented
module zxuno_regbank #(
   parameter logic [15:0] IOADDR    = 16'hFC3B,
   parameter logic [15:0] IODATA    = 16'hFD3B,
   parameter logic [7:0]  BASE      = 8'h00,
   parameter int          NREGS     = 8,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          a,
   input  logic                 iorq_n,
   input  logic                 rd_n,
   input  logic                 wr_n,
   input  logic [7:0]           din,
   input  logic                 autoinc,
   output logic [7:0]           dout,
   output logic                 oe,
   output logic [7:0]           addr,
   output logic [8*NREGS-1:0]   regs_out,
   output logic                 read_from_reg,
   output logic                 write_to_reg,
   output logic                 regaddr_changed
);

   localparam logic [8:0] NREGS9 = 9'(NREGS);

   logic ra, wa, rd, wd;
   logic ra_h_q, wa_h_q, rd_h_q, wd_h_q;
   // Set by a data-access rising edge and cleared by its falling edge, so only
   // an access that began after reset release can auto-increment the address.
   logic rd_arm_q, rd_arm_d, wd_arm_q, wd_arm_d;
   logic wa_rise, rd_rise, wd_rise, rd_fall, wd_fall, do_inc;
   logic [7:0]         addr_q, addr_d;
   logic [8*NREGS-1:0] regs_q, regs_d;
   logic               rfr_q, rfr_d, wtr_q, wtr_d, chg_q, chg_d;
   logic [8:0]         off;
   logic [5:0]         idx;
   logic               local_hit;

   always_comb begin
      ra = !iorq_n && (a == IOADDR) && !rd_n && wr_n;
      wa = !iorq_n && (a == IOADDR) && !wr_n && rd_n;
      rd = !iorq_n && (a == IODATA) && !rd_n && wr_n;
      wd = !iorq_n && (a == IODATA) && !wr_n && rd_n;
   end

   always_comb begin
      wa_rise = wa && !wa_h_q;
      rd_rise = rd && !rd_h_q;
      wd_rise = wd && !wd_h_q;
      rd_fall = !rd && rd_h_q && rd_arm_q;
      wd_fall = !wd && wd_h_q && wd_arm_q;
      do_inc  = autoinc && (rd_fall || wd_fall);
   end

   // An address below BASE wraps the 9-bit offset above 255, so one unsigned
   // compare covers both ends of the local window.
   always_comb begin
      off       = {1'b0, addr_q} - {1'b0, BASE};
      local_hit = (off < NREGS9);
      idx       = off[5:0];
   end

   always_comb begin
      addr_d   = addr_q;
      regs_d   = regs_q;
      rd_arm_d = rd_arm_q;
      wd_arm_d = wd_arm_q;
      chg_d    = 1'b0;
      rfr_d    = rd_rise && !local_hit;
      wtr_d    = wd_rise && !local_hit;

      if (rd_rise)      rd_arm_d = 1'b1;
      else if (!rd)     rd_arm_d = 1'b0;
      if (wd_rise)      wd_arm_d = 1'b1;
      else if (!wd)     wd_arm_d = 1'b0;

      // An address-port load in the same clock as a data-access end wins.
      if (wa_rise) begin
         addr_d = din;
         chg_d  = 1'b1;
      end else if (do_inc) begin
         addr_d = addr_q + 8'd1;
         chg_d  = 1'b1;
      end

      if (wd_rise && local_hit) regs_d[8*idx +: 8] = din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ra_h_q   <= 1'b1;
         wa_h_q   <= 1'b1;
         rd_h_q   <= 1'b1;
         wd_h_q   <= 1'b1;
         rd_arm_q <= 1'b0;
         wd_arm_q <= 1'b0;
         addr_q   <= 8'h00;
         regs_q   <= {NREGS{RESET_VAL}};
         rfr_q    <= 1'b0;
         wtr_q    <= 1'b0;
         chg_q    <= 1'b1;
      end else begin
         ra_h_q   <= ra;
         wa_h_q   <= wa;
         rd_h_q   <= rd;
         wd_h_q   <= wd;
         rd_arm_q <= rd_arm_d;
         wd_arm_q <= wd_arm_d;
         addr_q   <= addr_d;
         regs_q   <= regs_d;
         rfr_q    <= rfr_d;
         wtr_q    <= wtr_d;
         chg_q    <= chg_d;
      end
   end

   // The read path follows the access level, so dout is valid for the whole
   // bus cycle; a non-local data read leaves the bus to the external device.
   always_comb begin
      oe   = 1'b0;
      dout = addr_q;
      if (ra) begin
         oe = 1'b1;
      end else if (rd && local_hit) begin
         oe   = 1'b1;
         dout = regs_q[8*idx +: 8];
      end
   end

   assign addr            = addr_q;
   assign regs_out        = regs_q;
   assign read_from_reg   = rfr_q;
   assign write_to_reg    = wtr_q;
   assign regaddr_changed = chg_q;

endmodule

// File: tb/tb_zxuno_regbank.sv
// tb/tb_zxuno_regbank.sv - directed-vector bench for zxuno_regbank
module tb_zxuno_regbank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic        iorq_n, rd_n, wr_n;
   logic [7:0]  din;
   logic        autoinc;
   logic [7:0]  dout;
   logic        oe;
   logic [7:0]  addr;
   logic [63:0] regs_out;
   logic        read_from_reg, write_to_reg, regaddr_changed;

   int total = 0;
   int bad   = 0;
   int wtr_cnt = 0, rfr_cnt = 0, chg_cnt = 0;
   logic [7:0] rdata;
   logic       rdoe;

   always #5 clk = ~clk;

   zxuno_regbank #(
      .IOADDR(16'hFC3B), .IODATA(16'hFD3B), .BASE(8'h00), .NREGS(8), .RESET_VAL(8'hC3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .din(din), .autoinc(autoinc), .dout(dout), .oe(oe), .addr(addr),
      .regs_out(regs_out), .read_from_reg(read_from_reg), .write_to_reg(write_to_reg),
      .regaddr_changed(regaddr_changed)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         wtr_cnt += int'(write_to_reg);
         rfr_cnt += int'(read_from_reg);
         chg_cnt += int'(regaddr_changed);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      wtr_cnt = 0;
      rfr_cnt = 0;
      chg_cnt = 0;
   endtask

   // One bus cycle held for 'hold' clocks, then two idle clocks. Read data
   // is sampled at the end of the access, before the strobes are released.
   task automatic io_access(input logic [15:0] adr, input logic is_wr,
                            input logic [7:0] data, input int hold,
                            output logic [7:0] rd_data, output logic rd_oe);
      @(negedge clk);
      a = adr; din = data; iorq_n = 1'b0; rd_n = is_wr; wr_n = !is_wr;
      repeat (hold) @(negedge clk);
      #1;
      rd_data = dout;
      rd_oe   = oe;
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; autoinc = 1'b0; a = 16'h0000; din = 8'h00;
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      check("rst_addr", 64'(addr), 64'h00);
      check("rst_regs", regs_out, {8{8'hC3}});
      check("rst_chg", 64'(regaddr_changed), 64'h1);
      check("rst_wtr", 64'(write_to_reg), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_chg", 64'(regaddr_changed), 64'h0);
      clear_counts();

      // address port write, held 4 clocks, then read back
      io_access(16'hFC3B, 1'b1, 8'h03, 4, rdata, rdoe);
      check("wa_addr", 64'(addr), 64'h03);
      check("wa_chg_pulses", 64'(chg_cnt), 64'd1);
      io_access(16'hFC3B, 1'b0, 8'h00, 2, rdata, rdoe);
      check("ra_dout", 64'(rdata), 64'h03);
      check("ra_oe", 64'(rdoe), 64'h1);

      // local data write/read at addr 03
      clear_counts();
      io_access(16'hFD3B, 1'b1, 8'h5A, 2, rdata, rdoe);
      check("wd_local_reg3", 64'(regs_out[31:24]), 64'h5A);
      io_access(16'hFD3B, 1'b0, 8'h00, 2, rdata, rdoe);
      check("rd_local_dout", 64'(rdata), 64'h5A);
      check("rd_local_oe", 64'(rdoe), 64'h1);
      check("local_no_wtr", 64'(wtr_cnt), 64'd0);
      check("local_no_rfr", 64'(rfr_cnt), 64'd0);

      // external address A0: long write, then read
      io_access(16'hFC3B, 1'b1, 8'hA0, 2, rdata, rdoe);
      clear_counts();
      io_access(16'hFD3B, 1'b1, 8'h11, 5, rdata, rdoe);
      check("ext_wtr_pulses", 64'(wtr_cnt), 64'd1);
      io_access(16'hFD3B, 1'b0, 8'h00, 3, rdata, rdoe);
      check("ext_rfr_pulses", 64'(rfr_cnt), 64'd1);
      check("ext_rd_oe", 64'(rdoe), 64'h0);
      check("ext_rd_dout", 64'(rdata), 64'hA0);
      check("ext_regs", regs_out, 64'hC3C3C3C35AC3C3C3);
      check("ext_no_chg", 64'(chg_cnt), 64'd0);

      // auto-increment across the end of the local window
      autoinc = 1'b1;
      io_access(16'hFC3B, 1'b1, 8'h06, 2, rdata, rdoe);
      check("ai_addr_load", 64'(addr), 64'h06);
      clear_counts();
      io_access(16'hFD3B, 1'b1, 8'h01, 3, rdata, rdoe);
      io_access(16'hFD3B, 1'b1, 8'h02, 1, rdata, rdoe);
      io_access(16'hFD3B, 1'b1, 8'h03, 4, rdata, rdoe);
      check("ai_regs", regs_out, 64'h0201C3C35AC3C3C3);
      check("ai_wtr_pulses", 64'(wtr_cnt), 64'd1);
      check("ai_addr_end", 64'(addr), 64'h09);
      check("ai_chg_pulses", 64'(chg_cnt), 64'd3);

      // wrap FF -> 00 on a read
      io_access(16'hFC3B, 1'b1, 8'hFF, 2, rdata, rdoe);
      clear_counts();
      io_access(16'hFD3B, 1'b0, 8'h00, 3, rdata, rdoe);
      check("wrap_dout_stable", 64'(rdata), 64'hFF);
      check("wrap_addr", 64'(addr), 64'h00);
      check("wrap_rfr", 64'(rfr_cnt), 64'd1);
      check("wrap_chg", 64'(chg_cnt), 64'd1);

      // reset in the middle of a data write
      autoinc = 1'b0;
      io_access(16'hFC3B, 1'b1, 8'h05, 2, rdata, rdoe);
      check("mid_addr_pre", 64'(addr), 64'h05);
      @(negedge clk);
      a = 16'hFD3B; din = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("mid_reg5_written", 64'(regs_out[47:40]), 64'h77);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mid_rst_regs", regs_out, {8{8'hC3}});
      rst_n = 1'b1;
      din = 8'h55;
      @(negedge clk);
      #1;
      clear_counts();
      repeat (3) @(negedge clk);
      #1;
      check("mid_regs_after", regs_out, {8{8'hC3}});
      check("mid_addr_after", 64'(addr), 64'h00);
      check("mid_no_wtr", 64'(wtr_cnt), 64'd0);
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("mid_addr_end", 64'(addr), 64'h00);
      check("mid_no_chg", 64'(chg_cnt), 64'd0);
      check("mid_regs_end", regs_out, {8{8'hC3}});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
